imm_chunker: RTL and testbench

IMM_CHUNKER -- requirements
Module: imm_chunker

---
 rtl/imm_chunker_pkg.sv | 39 +++
 rtl/imm_chunker_if.sv | 30 +++
 rtl/imm_fit_check.sv | 28 ++
 rtl/imm_chunker.sv | 140 ++++++++++++++
 tb/tb_imm_chunker.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_chunker_pkg.sv
// Shared definitions for the immediate chunker: FSM states, default geometry,
// index width helper and the "fits in one sign-extended immediate" test.
package imm_chunker_pkg;

  localparam int DEF_N      = 32;
  localparam int DEF_K      = 8;
  localparam int DEF_CHUNKS = DEF_N / DEF_K;

  // Widest operand the fits() helper can examine.
  localparam int FITS_MAX_N = 256;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Width of the chunk index, never narrower than one bit.
  function automatic int idx_width(input int n, input int k);
    return (n / k > 1) ? $clog2(n / k) : 1;
  endfunction

  // True when value[n-1:k-1] is all zeros or all ones, i.e. the constant is
  // the sign extension of its low k bits. Bits at or above n are ignored.
  function automatic logic fits(input logic [FITS_MAX_N-1:0] value,
                                input int n, input int k);
    logic all0;
    logic all1;
    all0 = 1'b1;
    all1 = 1'b1;
    for (int i = 0; i < FITS_MAX_N; i++) begin
      if (i >= k - 1 && i < n) begin
        if (value[i]) all0 = 1'b0;
        else          all1 = 1'b0;
      end
    end
    return all0 || all1;
  endfunction

endpackage

// File: rtl/imm_chunker_if.sv
// Handshake bundle of the immediate chunker: the wide-constant input stream
// and the immediate-beat output stream. master = environment, slave = chunker.
interface imm_chunker_if #(
  parameter int N = imm_chunker_pkg::DEF_N,
  parameter int K = imm_chunker_pkg::DEF_K
) ();

  localparam int IW = imm_chunker_pkg::idx_width(N, K);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_value;
  logic          out_valid;
  logic          out_ready;
  logic [K-1:0]  out_imm;
  logic [IW-1:0] out_idx;
  logic          out_first;
  logic          out_last;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_imm, out_idx, out_first, out_last
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_imm, out_idx, out_first, out_last
  );

endinterface

// File: rtl/imm_fit_check.sv
// Combinational classifier for an incoming constant: does it fit a single
// sign-extended K-bit immediate, and which K-bit chunks are nonzero.
module imm_fit_check
  import imm_chunker_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = DEF_K
) (
  input  logic [N-1:0]   value,
  output logic           fit,
  output logic [N/K-1:0] nz_mask
);

  localparam int NC = N / K;

  logic [FITS_MAX_N-1:0] value_ext;

  // Classify the constant and build the per-chunk nonzero mask.
  always_comb begin
    value_ext          = '0;
    value_ext[N-1:0]   = value;
    fit                = fits(value_ext, N, K);
    for (int i = 0; i < NC; i++) begin
      nz_mask[i] = |value[i*K +: K];
    end
  end

endmodule

// File: rtl/imm_chunker.sv
// Immediate chunker: splits a wide constant into K-bit immediate beats.
// A constant that is the sign extension of its low K bits goes out as one
// beat; otherwise every chunk is emitted low to high.
// Build option: define IMM_CHUNKER_SKIP_ZERO_EN to drop all-zero chunks from
// multi-beat constants (out_idx still reports the true chunk position).
module imm_chunker
  import imm_chunker_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = DEF_K
) (
  input logic          clk,
  input logic          rst_n,
  imm_chunker_if.slave bus
);

  localparam int NC = N / K;
  localparam int IW = idx_width(N, K);

  state_t        state;
  logic [N-1:0]  val_q;
  logic [NC-1:0] mask_q;     // chunks of val_q still to be emitted (by position)

  logic          fit;
  logic [NC-1:0] nz_mask;
  logic [NC-1:0] mask_in;
  logic          accept;

  int            first_i;
  logic [K-1:0]  first_imm;
  logic          first_last;
  int            next_i;
  logic [K-1:0]  next_imm;
  logic          next_last;

  imm_fit_check #(.N(N), .K(K)) u_fit (
    .value   (bus.in_value),
    .fit     (fit),
    .nz_mask (nz_mask)
  );

  // True when any chunk strictly above position j is selected in m.
  function automatic logic has_above(input logic [NC-1:0] m, input int j);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (i > j && m[i]) r = 1'b1;
    end
    return r;
  endfunction

  // A new constant is taken when idle, or when the final beat leaves this cycle.
  assign bus.in_ready = (state == IDLE) ||
                        (bus.out_valid && bus.out_ready && bus.out_last);
  assign accept       = bus.in_valid && bus.in_ready;

  // Select which chunk positions of the incoming constant will be emitted.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (defaults
    // first) so no latch is inferred.
    mask_in = '1;
    if (fit) begin
      mask_in = NC'(1);
    end else begin
`ifdef IMM_CHUNKER_SKIP_ZERO_EN
      mask_in = nz_mask;
`else
      mask_in = '1;
`endif
    end
  end

`ifndef IMM_CHUNKER_SKIP_ZERO_EN
  // Every chunk is emitted, so the nonzero mask has no consumer here.
  logic unused_nz;
  assign unused_nz = ^nz_mask;
`endif

  // Locate the first beat of an incoming constant and the beat after the
  // current one for the registered constant.
  always_comb begin
    first_i   = 0;
    first_imm = bus.in_value[K-1:0];
    for (int i = NC - 1; i >= 0; i--) begin
      if (mask_in[i]) begin
        first_i   = i;
        first_imm = bus.in_value[i*K +: K];
      end
    end
    first_last = !has_above(mask_in, first_i);

    next_i   = int'(bus.out_idx);
    next_imm = bus.out_imm;
    for (int i = NC - 1; i >= 0; i--) begin
      if (mask_q[i] && i > int'(bus.out_idx)) begin
        next_i   = i;
        next_imm = val_q[i*K +: K];
      end
    end
    next_last = !has_above(mask_q, next_i);
  end

  // FSM and registered beat outputs: load on accept, advance on handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the value/mask holding registers are cleared too, so nothing of
      // an aborted constant survives reset.
      state         <= IDLE;
      val_q         <= '0;
      mask_q        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_imm   <= '0;
      bus.out_idx   <= '0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
    end else if (accept) begin
      state         <= EMIT;
      val_q         <= bus.in_value;
      mask_q        <= mask_in;
      bus.out_valid <= 1'b1;
      bus.out_imm   <= first_imm;
      bus.out_idx   <= IW'(first_i);
      bus.out_first <= 1'b1;
      bus.out_last  <= first_last;
    end else if (state == EMIT && bus.out_ready) begin
      if (bus.out_last) begin
        state         <= IDLE;
        bus.out_valid <= 1'b0;
      end else begin
        bus.out_imm   <= next_imm;
        bus.out_idx   <= IW'(next_i);
        bus.out_first <= 1'b0;
        bus.out_last  <= next_last;
      end
    end
  end

endmodule

// File: tb/tb_imm_chunker.sv
// Self-checking bench for imm_chunker (N=32, K=8): directed table, hand-built
// multi-cycle sequences (stall, back-to-back, mid-stream reset) and random
// constants checked against a behavioural beat model.
module tb_imm_chunker;

  localparam int N  = 32;
  localparam int K  = 8;
  localparam int NC = N / K;
  localparam int IW = 2;

  typedef struct packed {
    logic [K-1:0]  imm;
    logic [IW-1:0] idx;
    logic          first;
    logic          last;
  } beat_t;

  typedef struct {
    logic [N-1:0] value;
    int           n;
    logic [7:0]   imm [4];
    int           idx [4];
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  imm_chunker_if #(.N(N), .K(K)) bus ();

  imm_chunker #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.imm   = bus.out_imm;
    b.idx   = bus.out_idx;
    b.first = bus.out_first;
    b.last  = bus.out_last;
    return b;
  endfunction

  // Reference model: beats a constant must produce, from the rules directly.
  task automatic build_exp(input logic [N-1:0] v, output beat_t q[$]);
    longint unsigned upper;
    longint unsigned ones;
    int c;
    beat_t b;
    q     = {};
    upper = 64'(v) >> (K - 1);
    ones  = (64'd1 << (N - K + 1)) - 1;
    if (upper == 0 || upper == ones) begin
      b = '{imm: v[K-1:0], idx: '0, first: 1'b1, last: 1'b1};
      q.push_back(b);
    end else begin
      for (int i = 0; i < NC; i++) begin
        c = int'((v >> (i * K)) & ((32'd1 << K) - 1));
`ifdef IMM_CHUNKER_SKIP_ZERO_EN
        if (c == 0) continue;
`endif
        b = '{imm: K'(c), idx: IW'(i), first: 1'b0, last: 1'b0};
        q.push_back(b);
      end
      q[0].first          = 1'b1;
      q[q.size()-1].last  = 1'b1;
    end
  endtask

  task automatic vec_to_q(input vec_t r, output beat_t q[$]);
    beat_t b;
    q = {};
    for (int j = 0; j < r.n; j++) begin
      b = '{imm: r.imm[j], idx: IW'(r.idx[j]), first: (j == 0), last: (j == r.n - 1)};
      q.push_back(b);
    end
  endtask

  // Offer one constant while idle, then follow its beats to the end.
  // Entered and left around a negative edge; out_ready is randomised with
  // ready_pct percent, and forced low on cycles whose stall_mask bit is set.
  task automatic run_stream(input logic [N-1:0] v, input beat_t exp_q[$],
                            input int ready_pct, input logic [63:0] stall_mask,
                            input string tag);
    beat_t q[$];
    beat_t got;
    int    cyc;
    q = exp_q;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_value  = v;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_value = $urandom;
    cyc = 0;
    while (q.size() > 0 && cyc < 300) begin
      bus.out_ready = !stall_mask[cyc[5:0]] && ($urandom_range(99) < ready_pct);
      if (cyc >= 64) bus.out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      got = cur_beat();
      check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_beat"}, 64'(got), 64'(q[0]));
      check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(bus.out_ready && q[0].last));
      if (bus.out_ready) void'(q.pop_front());
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_beats_left"}, 64'(q.size()), 64'd0);
    bus.out_ready = ($urandom_range(1) == 1);
    @(negedge clk);
    check({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  vec_t  vecs [9];
  beat_t q    [$];

  initial begin
    tests = 0;
    fails = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{32'hFFFFFF80, 1, '{8'h80, 8'h00, 8'h00, 8'h00}, '{0, 0, 0, 0}};
    vecs[1] = '{32'h0000007F, 1, '{8'h7F, 8'h00, 8'h00, 8'h00}, '{0, 0, 0, 0}};
    vecs[2] = '{32'h12345678, 4, '{8'h78, 8'h56, 8'h34, 8'h12}, '{0, 1, 2, 3}};
    vecs[3] = '{32'hFFFFFFFF, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, '{0, 0, 0, 0}};
    vecs[4] = '{32'h00000000, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, '{0, 0, 0, 0}};
    vecs[5] = '{32'hFFFF7FFF, 4, '{8'hFF, 8'h7F, 8'hFF, 8'hFF}, '{0, 1, 2, 3}};
`ifdef IMM_CHUNKER_SKIP_ZERO_EN
    vecs[6] = '{32'h00000100, 1, '{8'h01, 8'h00, 8'h00, 8'h00}, '{1, 0, 0, 0}};
    vecs[7] = '{32'h00000080, 1, '{8'h80, 8'h00, 8'h00, 8'h00}, '{0, 0, 0, 0}};
    vecs[8] = '{32'h80000000, 1, '{8'h80, 8'h00, 8'h00, 8'h00}, '{3, 0, 0, 0}};
`else
    vecs[6] = '{32'h00000100, 4, '{8'h00, 8'h01, 8'h00, 8'h00}, '{0, 1, 2, 3}};
    vecs[7] = '{32'h00000080, 4, '{8'h80, 8'h00, 8'h00, 8'h00}, '{0, 1, 2, 3}};
    vecs[8] = '{32'h80000000, 4, '{8'h00, 8'h00, 8'h00, 8'h80}, '{0, 1, 2, 3}};
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_imm",   64'(bus.out_imm),   64'd0);
    check("rst_idx",   64'(bus.out_idx),   64'd0);
    check("rst_first", 64'(bus.out_first), 64'd0);
    check("rst_last",  64'(bus.out_last),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_valid", 64'(bus.out_valid), 64'd0);

    // Directed table, full-rate and throttled consumer.
    for (int i = 0; i < 9; i++) begin
      vec_to_q(vecs[i], q);
      run_stream(vecs[i].value, q, 100, 64'd0, $sformatf("vec%0d", i));
    end
    for (int i = 0; i < 9; i++) begin
      vec_to_q(vecs[i], q);
      run_stream(vecs[i].value, q, 50, 64'd0, $sformatf("vec%0d_thr", i));
    end

    // Consumer stalls for five cycles on the second beat.
    vec_to_q(vecs[2], q);
    run_stream(vecs[2].value, q, 100, 64'h3E, "stall");

    // New constant offered during the final beat: taken with no bubble.
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_value  = 32'h12345678;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_value  = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_value = 32'h00000005;
    @(negedge clk);
    check("b2b_last_beat", 64'(cur_beat()), 64'({8'h12, 2'd3, 1'b0, 1'b1}));
    check("b2b_in_ready",  64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_value = 32'hDEADBEEF;
    @(negedge clk);
    check("b2b_valid", 64'(bus.out_valid), 64'd1);
    check("b2b_beat",  64'(cur_beat()), 64'({8'h05, 2'd0, 1'b1, 1'b1}));
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_idle", 64'(bus.out_valid), 64'd0);

    // Reset while the third beat is presented discards the rest.
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_value  = 32'h12345678;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_beat2", 64'(cur_beat()), 64'({8'h34, 2'd2, 1'b0, 1'b0}));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_ready", 64'(bus.in_ready),  64'd1);
    check("abort_imm",   64'(bus.out_imm),   64'd0);
    check("abort_idx",   64'(bus.out_idx),   64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_quiet", 64'(bus.out_valid), 64'd0);
    end

    // Random constants against the model.
    for (int t = 0; t < 60; t++) begin
      logic [N-1:0] v;
      logic [7:0]   b8;
      case ($urandom_range(3))
        0: v = $urandom;
        1: begin
          b8 = 8'($urandom);
          v  = {{(N-8){b8[7]}}, b8};
        end
        2: begin
          v = $urandom;
          for (int c = 0; c < NC; c++) begin
            if ($urandom_range(1) == 1) v[c*K +: K] = '0;
          end
        end
        default: v = 32'd1 << $urandom_range(31);
      endcase
      build_exp(v, q);
      run_stream(v, q, 70, 64'd0, $sformatf("rand%0d_%08h", t, v));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
